// File: rtl/parity_pkg.sv
// parity_pkg
//   Shared types and defaults for the parity stream unit.
//   - state_t    : ACC accepts beats, HOLD presents a finished result
//   - DEF_*      : default widths used by the top-level parameters
package parity_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_ERR_W = 16;

endpackage

// File: rtl/parity_reduce.sv
// parity_reduce
//   Combinational XOR reduction of one WIDTH-bit beat. Polarity (odd/even)
//   is not applied here; the caller folds it in once per packet.
//   Ports:
//     i_data   [WIDTH-1:0]  beat data
//     o_parity              XOR of all bits of i_data
module parity_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_parity
);

    // Running XOR chain; synthesis rebalances it into a tree.
    logic [WIDTH-1:0] w_chain;

    assign w_chain[0] = i_data[0];

    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
        assign w_chain[gi] = w_chain[gi-1] ^ i_data[gi];
    end

    assign o_parity = w_chain[WIDTH-1];

endmodule

// File: rtl/parity_stream_unit.sv
// parity_stream_unit
//   Accumulates parity over multi-beat packets and either emits the packet
//   parity (generate mode) or compares it with a received bit (check mode).
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     mode                     0 generate / 1 check, taken from first beat
//     in_valid/in_ready        beat handshake (in_ready registered)
//     in_data [WIDTH-1:0]      beat data
//     in_last, in_parity       end of packet, received parity (check mode)
//     out_valid/out_ready      result handshake
//     out_parity, out_error    packet parity, check-mode mismatch flag
//     out_beats [CNT_W-1:0]    beats in packet, saturating
//     err_count [ERR_W-1:0]    error packets since reset, saturating
module parity_stream_unit
    import parity_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter bit ODD   = 1'b0,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_error,
    output logic [CNT_W-1:0] out_beats,
    output logic [ERR_W-1:0] err_count
);

    state_t             r_state;
    logic               r_acc;
    logic [CNT_W-1:0]   r_beats;
    logic               r_pkt_mode;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_out_parity;
    logic               r_out_error;
    logic [CNT_W-1:0]   r_out_beats;
    logic [ERR_W-1:0]   r_err_count;

    logic               w_beat_par;
    logic               w_accept;
    logic               w_first;
    logic               w_acc_next;
    logic [CNT_W-1:0]   w_beats_next;
    logic               w_mode_eff;
    logic               w_par_next;
    logic               w_err_next;

    parity_reduce #(
        .WIDTH (WIDTH)
    ) u_reduce (
        .i_data   (in_data),
        .o_parity (w_beat_par)
    );

    // r_in_ready mirrors the ACC state, so acceptance never depends
    // combinationally on out_ready.
    assign w_accept     = in_valid & r_in_ready;
    assign w_first      = (r_beats == '0);
    assign w_acc_next   = r_acc ^ w_beat_par;
    assign w_beats_next = (&r_beats) ? r_beats : r_beats + CNT_W'(1);
    // A single-beat packet has not latched its mode yet, so use the live input.
    assign w_mode_eff   = w_first ? mode : r_pkt_mode;
    assign w_par_next   = w_acc_next ^ ODD;
    assign w_err_next   = w_mode_eff & (w_par_next ^ in_parity);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ACC;
            r_acc        <= 1'b0;
            r_beats      <= '0;
            r_pkt_mode   <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_parity <= 1'b0;
            r_out_error  <= 1'b0;
            r_out_beats  <= '0;
            r_err_count  <= '0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_next;
                        r_beats <= w_beats_next;
                        if (w_first) begin
                            r_pkt_mode <= mode;
                        end
                        if (in_last) begin
                            r_out_parity <= w_par_next;
                            r_out_error  <= w_err_next;
                            r_out_beats  <= w_beats_next;
                            if (w_err_next && !(&r_err_count)) begin
                                r_err_count <= r_err_count + ERR_W'(1);
                            end
                            r_state     <= ST_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_acc       <= 1'b0;
                        r_beats     <= '0;
                        r_state     <= ST_ACC;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_parity = r_out_parity;
    assign out_error  = r_out_error;
    assign out_beats  = r_out_beats;
    assign err_count  = r_err_count;

endmodule
